// File: rtl/mem_addr_gen.sv
// Multi-dimensional strided address generator feeding memory_core addr_in.
// Walks up to NUM_DIMS nested loops (dim 0 fastest) from a base address,
// issuing one address per accepted step and pulsing done at the end.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   clk_en           global enable; all state holds when low
//   flush            abort the running sequence, back to IDLE, no done
//   start            begin a sequence (IDLE only); latches the config below
//   dimensionality   active dimension count, clamped to NUM_DIMS
//   starting_addr    base address
//   strides/ranges   packed per-dimension config, dim 0 in the LSBs
//   step             consumer took addr_out this cycle
//   addr_out         current address, addr_valid qualifies it
//   done             one enabled-cycle pulse after the final step
//   iter_count       steps accepted in the current sequence
module mem_addr_gen #(
    parameter int NUM_DIMS = 6,
    parameter int ADDR_W   = 16,
    parameter int RANGE_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         flush,
    input  logic                         start,
    input  logic [3:0]                   dimensionality,
    input  logic [ADDR_W-1:0]            starting_addr,
    input  logic [NUM_DIMS*ADDR_W-1:0]   strides,
    input  logic [NUM_DIMS*RANGE_W-1:0]  ranges,
    input  logic                         step,
    output logic [ADDR_W-1:0]            addr_out,
    output logic                         addr_valid,
    output logic                         done,
    output logic [RANGE_W-1:0]           iter_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [NUM_DIMS-1:0] act_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   stride_q [NUM_DIMS];
    logic [RANGE_W-1:0]  range_q  [NUM_DIMS];
    logic [RANGE_W-1:0]  cnt_q    [NUM_DIMS];
    logic [RANGE_W-1:0]  cnt_d    [NUM_DIMS];
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                valid_q;
    logic                done_q;
    logic [RANGE_W-1:0]  iter_q;
    logic                carry;
    logic [3:0]          dims_clamped;

    assign dims_clamped = (dimensionality > 4'(NUM_DIMS)) ? 4'(NUM_DIMS)
                                                           : dimensionality;

    // Odometer advance. A carry surviving every active dimension means the
    // counters were all at range-1, i.e. the address just taken was the last.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < NUM_DIMS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (act_q[i] && carry) begin
                if (cnt_q[i] == range_q[i] - RANGE_W'(1)) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + RANGE_W'(1);
                    carry    = 1'b0;
                end
            end
        end
    end

    // Closed-form address of the advanced counters; only the low ADDR_W
    // bits of each counter can influence a modulo-2^ADDR_W result.
    always_comb begin
        addr_d = base_q;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (act_q[i]) begin
                addr_d = addr_d + cnt_d[i][ADDR_W-1:0] * stride_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            iter_q  <= '0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                stride_q[i] <= '0;
                range_q[i]  <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (clk_en) begin
            if (flush) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                iter_q  <= '0;
                for (int i = 0; i < NUM_DIMS; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        done_q <= 1'b0;
                        if (start) begin
                            state_q <= S_RUN;
                            base_q  <= starting_addr;
                            addr_q  <= starting_addr;
                            valid_q <= 1'b1;
                            iter_q  <= '0;
                            for (int i = 0; i < NUM_DIMS; i++) begin
                                act_q[i]    <= (4'(i) < dims_clamped);
                                stride_q[i] <= strides[i*ADDR_W +: ADDR_W];
                                // A zero range collapses to a single pass.
                                range_q[i]  <=
                                    (ranges[i*RANGE_W +: RANGE_W] == '0)
                                    ? RANGE_W'(1)
                                    : ranges[i*RANGE_W +: RANGE_W];
                                cnt_q[i]    <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (step) begin
                            iter_q <= iter_q + RANGE_W'(1);
                            for (int i = 0; i < NUM_DIMS; i++) begin
                                cnt_q[i] <= cnt_d[i];
                            end
                            if (carry) begin
                                state_q <= S_DONE;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q <= addr_d;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign done       = done_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_mem_addr_gen.sv
// Randomised scoreboard bench for mem_addr_gen.
// Expected address lists come from a mixed-radix enumeration model.
module tb_mem_addr_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en;
    logic         flush;
    logic         start;
    logic [3:0]   dimensionality;
    logic [15:0]  starting_addr;
    logic [95:0]  strides;
    logic [191:0] ranges;
    logic         step;
    logic [15:0]  addr_out;
    logic         addr_valid;
    logic         done;
    logic [31:0]  iter_count;

    typedef struct {
        logic [15:0] a;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;

    mem_addr_gen dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .flush         (flush),
        .start         (start),
        .dimensionality(dimensionality),
        .starting_addr (starting_addr),
        .strides       (strides),
        .ranges        (ranges),
        .step          (step),
        .addr_out      (addr_out),
        .addr_valid    (addr_valid),
        .done          (done),
        .iter_count    (iter_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sampled mid-cycle, compares the presented address against
    // the scoreboard head and retires it when the coming edge accepts it.
    always @(negedge clk) begin
        if (!reset) begin
            if (addr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("addr_out", addr_out, exp_q[0].a);
                    chk("iter_count", iter_count, exp_q[0].idx);
                    if (step && clk_en && !flush) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
            if (done && clk_en) done_cnt++;
        end
    end

    task automatic scramble();
        dimensionality = 4'($urandom);
        starting_addr  = 16'($urandom);
        strides        = {$urandom, $urandom, $urandom};
        ranges         = {$urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom};
    endtask

    // mode 0: step always, 1: step every other cycle, 2: random step/enable
    task automatic run_seq(input logic [3:0] d, input logic [15:0] b,
                           input logic [95:0] st, input logic [191:0] rg,
                           input int mode, input int flush_at,
                           input bit freeze, input bit probe);
        int     dc;
        longint r[6];
        longint total;
        longint rem;
        longint a;
        int     base_acc;
        int     base_done;
        bit     fin;
        dc    = (d > 6) ? 6 : int'(d);
        total = 1;
        for (int i = 0; i < dc; i++) begin
            r[i]  = (rg[i*32 +: 32] == 0) ? 1 : longint'(rg[i*32 +: 32]);
            total = total * r[i];
        end
        for (longint n = 0; n < total; n++) begin
            rem = n;
            a   = longint'(b);
            for (int i = 0; i < dc; i++) begin
                a   = a + (rem % r[i]) * longint'(st[i*16 +: 16]);
                rem = rem / r[i];
            end
            exp_q.push_back('{a: 16'(a), idx: int'(n)});
        end
        base_acc  = acc_cnt;
        base_done = done_cnt;
        dimensionality = d;
        starting_addr  = b;
        strides        = st;
        ranges         = rg;
        clk_en = 1'b1;
        step   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        chk("start_latency_valid", addr_valid, 1);
        chk("start_addr", addr_out, b);
        fin = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (flush_at >= 0 && acc_cnt - base_acc == flush_at) begin
                flush = 1'b1;
                step  = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                step  = 1'b0;
                exp_q.delete();
                chk("flush_valid", addr_valid, 0);
                chk("flush_iter", iter_count, 0);
                repeat (3) @(posedge clk);
                #1;
                chk("flush_no_done", done_cnt - base_done, 0);
                return;
            end
            case (mode)
                0: step = 1'b1;
                1: step = 1'(cyc % 2);
                default: step = 1'($urandom);
            endcase
            if (freeze && cyc >= 4 && cyc < 7) clk_en = 1'b0;
            else if (mode == 2) clk_en = ($urandom % 6) != 0;
            else clk_en = 1'b1;
            if (probe && cyc == 2) begin
                start = 1'b1;
                scramble();
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) fin = 1'b1;
        end
        clk_en = 1'b1;
        step   = 1'b0;
        if (!fin) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
            return;
        end
        chk("done_valid_low", addr_valid, 0);
        chk("final_iter", iter_count, total);
        @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - base_done, 1);
        chk("done_cleared", done, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        flush  = 1'b0;
        start  = 1'b0;
        step   = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_addr", addr_out, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter_count, 0);
        step = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_step_ignored", addr_valid, 0);

        run_seq(4'd3, 16'd0, {48'd0, 16'd9, 16'd3, 16'd1},
                {96'd0, 32'd3, 32'd3, 32'd3}, 0, -1, 1'b0, 1'b0);
        run_seq(4'd2, 16'd10, {64'd0, 16'd100, 16'd4},
                {128'd0, 32'd3, 32'd2}, 1, -1, 1'b0, 1'b0);
        run_seq(4'd1, 16'h4000, {80'd0, 16'h8000},
                {160'd0, 32'd4}, 0, -1, 1'b0, 1'b0);
        run_seq(4'd3, 16'd0, {48'd0, 16'd9, 16'd3, 16'd1},
                {96'd0, 32'd3, 32'd3, 32'd3}, 0, 5, 1'b0, 1'b0);
        run_seq(4'd3, 16'd0, {48'd0, 16'd9, 16'd3, 16'd1},
                {96'd0, 32'd3, 32'd3, 32'd3}, 0, -1, 1'b1, 1'b1);
        run_seq(4'd0, 16'h1234, {96{1'b1}}, {192{1'b1}}, 0, -1,
                1'b0, 1'b0);
        run_seq(4'd3, 16'h0100, {48'd0, 16'd7, 16'd5, 16'd2},
                {96'd0, 32'd2, 32'd0, 32'd3}, 1, -1, 1'b0, 1'b1);
        run_seq(4'd9, 16'hFFF0, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
                16'd6}, {32'd2, 32'd1, 32'd2, 32'd0, 32'd2, 32'd2},
                0, -1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            logic [191:0] rg;
            for (int i = 0; i < 6; i++) rg[i*32 +: 32] = $urandom_range(0, 3);
            run_seq(4'($urandom_range(0, 9)), 16'($urandom),
                    {$urandom, $urandom, $urandom}, rg, 2,
                    (k == 3) ? 7 : -1, 1'(k % 2), 1'(k == 1));
        end

        // Reset mid-sequence behaves like power-on reset and gives no done.
        dimensionality = 4'd1;
        starting_addr  = 16'd50;
        strides        = 96'd1;
        ranges         = 192'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        step  = 1'b1;
        exp_q.push_back('{a: 16'd50, idx: 0});
        exp_q.push_back('{a: 16'd51, idx: 1});
        exp_q.push_back('{a: 16'd52, idx: 2});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step  = 1'b0;
        exp_q.delete();
        chk("midrst_valid", addr_valid, 0);
        chk("midrst_iter", iter_count, 0);
        chk("midrst_addr", addr_out, 0);
        chk("midrst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_addr_gen.md
Name: mem_addr_gen

Overview:
- Multi-dimensional strided address generator.
- Sits directly upstream of memory_core and drives its addr_in, one address per accepted step.
- Walks a nested loop of up to NUM_DIMS dimensions, each with its own stride and range, starting from a base address.
- Raises addr_valid while a sequence is active and pulses done after the last address has been consumed.

Parameters:
- NUM_DIMS, 6, maximum number of loop dimensions.
- ADDR_W, 16, address and stride width.
- RANGE_W, 32, per-dimension range and iteration-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  global clock enable; when 0, all state holds.
- flush  in  1  abort the current sequence and return to IDLE.
- start  in  1  begin a sequence; honoured only in IDLE.
- dimensionality  in  4  number of active dimensions; values above NUM_DIMS are clamped to NUM_DIMS.
- starting_addr  in  ADDR_W  base address.
- strides  in  NUM_DIMS*ADDR_W  packed strides; dim 0 in the LSBs.
- ranges  in  NUM_DIMS*RANGE_W  packed ranges; dim 0 in the LSBs.
- step  in  1  consumer has taken addr_out this cycle.
- addr_out  out  ADDR_W  current address.
- addr_valid  out  1  addr_out is valid.
- done  out  1  one-cycle pulse after the final address is accepted.
- iter_count  out  RANGE_W  number of steps accepted in the current sequence.

Behaviour:
- Reset (sync, highest priority): state=IDLE, all loop counters 0, addr_out=0, addr_valid=0, done=0, iter_count=0.
- All state updates require clk_en=1, except reset. With clk_en=0, every register holds (including done, which then stays high until an enabled cycle).
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 latches dimensionality (clamped), starting_addr, strides and ranges, with any range of 0 treated as 1.
  - Clears cnt[0..NUM_DIMS-1] and iter_count.
  - addr_out <= starting_addr, addr_valid <= 1, and moves to RUN.
  - Output is valid the cycle after start: latency 1.
- Config inputs are ignored outside the start cycle. Changing them mid-sequence has no effect.
- Address rule:
  - addr_out = starting_addr + sum over active dims i of cnt[i]*stride[i].
  - Truncated modulo 2^ADDR_W; wrap-around is legal and silent.
  - Inactive dims contribute 0.
  - May be computed incrementally; it must match the closed form every cycle.
- RUN with step=1:
  - iter_count increments.
  - cnt[0] increments. If cnt[0] was range[0]-1, it wraps to 0 and carries into cnt[1], and so on (odometer order, dim 0 fastest).
  - If every active counter is at range-1 (the final address), go to DONE with addr_valid <= 0.
  - Otherwise addr_out <= the new address on the next cycle.
- RUN with step=0: all outputs hold.
- dimensionality=0: exactly one address (starting_addr) is issued; the first step completes the sequence.
- Total addresses issued = product of the active ranges.
- DONE: done=1 for exactly one enabled cycle, then IDLE. done is 0 in every other state.
- start while in RUN or DONE is ignored. start is not sampled in the DONE cycle.
- step while addr_valid=0 is ignored; it has no effect on any counter.
- flush=1 (takes priority over start and step):
  - Next state IDLE, addr_valid <= 0, counters cleared, iter_count cleared.
  - done is not pulsed.
- Reset mid-sequence: identical to power-on reset. No partial done is produced.
- Arithmetic: cnt[i] is RANGE_W wide. The multiply/accumulate result is truncated to ADDR_W; no saturation.

Test Plan:
- dims=3, strides 1/3/9, ranges 3/3/3, start_addr 0, step held high: addr_out=0,1,2,...,26 on consecutive cycles; addr_valid drops after the 27th; done pulses once; iter_count=27.
- dims=2, strides 4/100, ranges 2/3, base 10, step every other cycle: addresses 10,14,110,114,210,214, each held while step=0; done after the 6th step.
- Wrap: dims=1, stride 16'h8000, range 4, base 16'h4000: addresses 4000, C000, 4000, C000; done pulses.
- Flush after 5 steps of the first scenario: next cycle addr_valid=0, iter_count=0, no done. A new start restarts at address 0.
- clk_en=0 for 3 cycles mid-sequence with step=1: addr_out and iter_count frozen. Resume continues without skipping any address.
- dimensionality=0 or any range=0 treated as 1: exactly one address per collapsed loop. start asserted during RUN has no effect on the sequence.
